// File: rtl/master_port_pkg.sv
// Bus definitions shared by the master port, slave ports and arbiter:
// instruction codes, FSM states, frame geometry and mode encoding.
package master_port_pkg;

  typedef enum logic [1:0] {
    INS_IDLE  = 2'b00,
    INS_READ  = 2'b01,
    INS_WRITE = 2'b10,
    INS_RSVD  = 2'b11
  } instr_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_REQ,
    S_HEADER,
    S_WDATA,
    S_WACK,
    S_RWAIT,
    S_RDATA,
    S_DONE,
    S_REARM
  } state_t;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  function automatic int hdr_len(
    input int sel_w,
    input int addr_w
  );
    return sel_w + addr_w;
  endfunction

  function automatic int max2(
    input int a,
    input int b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/master_port_frame_shifter.sv
// Loadable right-shift register with serial in/out and bit counter,
// reused for the header, write data and read data phases.
module frame_shifter #(
  parameter int W  = 14,
  parameter int DW = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic [W-1:0]  i_load_val,
  input  logic          i_shift,
  input  logic          i_sin,
  output logic          o_sout,
  output logic [DW-1:0] o_word,
  output logic [CW-1:0] o_cnt
);

  logic [W-1:0]  r_sr;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_sr  <= i_load_val;
      r_cnt <= '0;
    end else if (i_shift) begin
      r_sr  <= {i_sin, r_sr[W-1:1]};
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_sout = r_sr[0];

  // word completed by the bit arriving this cycle
  assign o_word = {i_sin, r_sr[W-1 -: DW-1]};
  assign o_cnt  = r_cnt;

endmodule

// File: rtl/master_port.sv
// Bus master port: takes one read/write command, wins the bus,
// sends a serial frame and returns a one-cycle done pulse.
module master_port
  import master_port_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int SEL_WIDTH  = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            instruction,
  input  logic [SEL_WIDTH-1:0]  slave_sel,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  tx_done,
  output logic                  tx_err,
  output logic                  mreq,
  input  logic                  mgrant,
  output logic                  mvalid,
  output logic                  mmode,
  output logic                  mwdata,
  input  logic                  mrdata,
  input  logic                  sready
);

  localparam int HDR = hdr_len(SEL_WIDTH, ADDR_WIDTH);
  localparam int SW  = max2(HDR, DATA_WIDTH);
  localparam int CW  = $clog2(SW + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);

  state_t r_state;
  state_t w_next;

  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_mode;
  logic                  r_err;
  logic [TW-1:0]         r_wait;

  logic                  w_load;
  logic [SW-1:0]         w_load_val;
  logic                  w_shift;
  logic                  w_err;
  logic                  w_dout_ld;
  logic                  w_wait_inc;
  logic                  w_sout;
  logic [DATA_WIDTH-1:0] w_word;
  logic [CW-1:0]         w_cnt;
  logic                  w_rd;
  logic                  w_wr;
  logic                  w_hdr_last;
  logic                  w_dat_last;
  logic                  w_tmo;

  assign w_rd       = (instruction == INS_READ);
  assign w_wr       = (instruction == INS_WRITE);
  assign w_hdr_last = (w_cnt == CW'(HDR - 1));
  assign w_dat_last = (w_cnt == CW'(DATA_WIDTH - 1));
  assign w_tmo      = (r_wait == TW'(TIMEOUT - 1));

  frame_shifter #(
    .W  (SW),
    .DW (DATA_WIDTH),
    .CW (CW)
  ) u_shift (
    .clk        (clk),
    .rst_n      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_shift    (w_shift),
    .i_sin      (mrdata),
    .o_sout     (w_sout),
    .o_word     (w_word),
    .o_cnt      (w_cnt)
  );

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = '0;
    w_shift    = 1'b0;
    w_err      = 1'b0;
    w_dout_ld  = 1'b0;
    w_wait_inc = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        unique case (1'b1)
          w_rd, w_wr: begin
            w_load     = 1'b1;
            w_load_val = SW'({address, slave_sel});
            w_next     = S_REQ;
          end
          default: ;
        endcase
      end
      S_REQ: begin
        if (mgrant) w_next = S_HEADER;
      end
      S_HEADER: begin
        if (!mgrant) begin
          w_next = S_DONE;
          w_err  = 1'b1;
        end else if (w_hdr_last) begin
          if (r_mode == MODE_WRITE) begin
            w_load     = 1'b1;
            w_load_val = SW'(r_wdata);
            w_next     = S_WDATA;
          end else begin
            w_next = S_RWAIT;
          end
        end else begin
          w_shift = 1'b1;
        end
      end
      S_WDATA: begin
        if (!mgrant) begin
          w_next = S_DONE;
          w_err  = 1'b1;
        end else begin
          w_shift = 1'b1;
          if (w_dat_last) w_next = S_WACK;
        end
      end
      S_WACK, S_RWAIT: begin
        if (!mgrant) begin
          w_next = S_DONE;
          w_err  = 1'b1;
        end else if (sready) begin
          if (r_state == S_WACK) begin
            w_next = S_DONE;
          end else begin
            // clear the shifter so the read word starts clean
            w_load = 1'b1;
            w_next = S_RDATA;
          end
        end else if (w_tmo) begin
          w_next = S_DONE;
          w_err  = 1'b1;
        end else begin
          w_wait_inc = 1'b1;
        end
      end
      S_RDATA: begin
        if (!mgrant) begin
          w_next = S_DONE;
          w_err  = 1'b1;
        end else begin
          w_shift = 1'b1;
          if (w_dat_last) begin
            w_dout_ld = 1'b1;
            w_next    = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_next = S_REARM;
      end
      S_REARM: begin
        if (instruction == INS_IDLE) w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_wdata <= '0;
      r_mode  <= MODE_READ;
      r_err   <= 1'b0;
      r_wait  <= '0;
      r_dout  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_next == S_REQ) begin
        r_wdata <= data_in;
        r_mode  <= w_wr ? MODE_WRITE : MODE_READ;
      end
      if (w_next == S_DONE) r_err <= w_err;
      r_wait <= w_wait_inc ? r_wait + 1'b1 : '0;
      if (w_dout_ld) r_dout <= w_word;
    end
  end

  assign mreq     = (r_state != S_IDLE) &&
                    (r_state != S_DONE) &&
                    (r_state != S_REARM);
  assign mvalid   = (r_state == S_HEADER) ||
                    (r_state == S_WDATA);
  assign mmode    = mreq & r_mode;
  assign mwdata   = mvalid & w_sout;
  assign tx_done  = (r_state == S_DONE);
  assign tx_err   = tx_done & r_err;
  assign data_out = r_dout;

endmodule
